opb_decode_stage: RTL and testbench

//  Decode-side producer for the ALU operand-B select path. Takes fetched instructions

---
 rtl/opb_decode_stage_pkg.sv | 35 +++
 rtl/opb_skid_buf.sv | 58 +++++
 rtl/opb_decode_stage.sv | 76 +++++++
 tb/tb_opb_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_decode_stage_pkg.sv
// Shared opcode and operand-B select constants plus the decoded entry layout.
// Imported by the decode stage and by the consuming operand-B mux.
package opb_decode_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] OPB_RSB = 2'd0;
  localparam logic [1:0] OPB_PC  = 2'd1;
  localparam logic [1:0] OPB_IMI = 2'd2;
  localparam logic [1:0] OPB_IMS = 2'd3;

  typedef struct packed {
    logic [1:0]      sel;
    logic [XLEN-1:0] imi;
    logic [XLEN-1:0] ims;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs2;
    logic            illegal;
  } opb_entry_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/opb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; registered in_ready.
// Ports: clk, reset, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module opb_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         consume;

  // Ready only depends on state, so it never combinationally follows out_ready.
  assign in_ready  = !skid_valid && !reset;
  assign accept    = in_valid && in_ready;
  assign consume   = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      // skid_valid implies !in_ready, so skid and input never compete
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/opb_decode_stage.sv
// Decodes opcode into operand-B select, extracts I/S immediates, rs2 and PC,
// and registers them through a 2-entry skid buffer toward execute.
module opb_decode_stage
  import opb_decode_stage_pkg::*;
#(
  parameter int XLEN_P = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [31:0]       io_in_inst,
  input  logic [XLEN_P-1:0] io_in_pc,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [1:0]        io_opb_sel,
  output logic [XLEN_P-1:0] io_opb_imi,
  output logic [XLEN_P-1:0] io_opb_ims,
  output logic [XLEN_P-1:0] io_opb_pc,
  output logic [4:0]        io_rs2_addr,
  output logic              io_illegal
);

  opb_entry_t dec;
  opb_entry_t held;
  logic [6:0] opc;
  logic       unused_bits;

  // rs1/funct3 are not needed on the operand-B path
  assign unused_bits = ^io_in_inst[19:12];
  assign opc         = io_in_inst[6:0];

  always_comb begin
    dec.imi     = sext12(io_in_inst[31:20]);
    dec.ims     = sext12({io_in_inst[31:25], io_in_inst[11:7]});
    dec.pc      = io_in_pc;
    dec.rs2     = io_in_inst[24:20];
    dec.sel     = OPB_RSB;
    dec.illegal = 1'b0;
    unique case (1'b1)
      (opc == OPC_OP),
      (opc == OPC_BRANCH): dec.sel = OPB_RSB;
      (opc == OPC_LUI),
      (opc == OPC_AUIPC),
      (opc == OPC_JAL):    dec.sel = OPB_PC;
      (opc == OPC_OPIMM),
      (opc == OPC_LOAD),
      (opc == OPC_JALR):   dec.sel = OPB_IMI;
      (opc == OPC_STORE):  dec.sel = OPB_IMS;
      default:             dec.illegal = 1'b1;
    endcase
  end

  opb_skid_buf #(
    .W($bits(opb_entry_t))
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (io_flush),
    .in_valid (io_in_valid),
    .in_ready (io_in_ready),
    .in_data  (dec),
    .out_valid(io_out_valid),
    .out_ready(io_out_ready),
    .out_data (held)
  );

  assign io_opb_sel  = held.sel;
  assign io_opb_imi  = held.imi;
  assign io_opb_ims  = held.ims;
  assign io_opb_pc   = held.pc;
  assign io_rs2_addr = held.rs2;
  assign io_illegal  = held.illegal;

endmodule

// File: tb/tb_opb_decode_stage.sv
// Directed bench for opb_decode_stage with a scoreboard of decoded entries.
// Independent reference decode; negedge monitor pushes on accept, pops on consume.
module tb_opb_decode_stage;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] imi;
    logic [31:0] ims;
    logic [31:0] pc;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  opb_sel;
  logic [31:0] opb_imi;
  logic [31:0] opb_ims;
  logic [31:0] opb_pc;
  logic [4:0]  rs2_addr;
  logic        illegal;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  opb_decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .io_in_valid (in_valid),
    .io_in_ready (in_ready),
    .io_in_inst  (in_inst),
    .io_in_pc    (in_pc),
    .io_flush    (flush),
    .io_out_valid(out_valid),
    .io_out_ready(out_ready),
    .io_opb_sel  (opb_sel),
    .io_opb_imi  (opb_imi),
    .io_opb_ims  (opb_ims),
    .io_opb_pc   (opb_pc),
    .io_rs2_addr (rs2_addr),
    .io_illegal  (illegal)
  );

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t m;
    m.imi = {{20{i[31]}}, i[31:20]};
    m.ims = {{20{i[31]}}, i[31:25], i[11:7]};
    m.pc  = p;
    m.rs2 = i[24:20];
    m.ill = 1'b0;
    case (i[6:0])
      7'h33, 7'h63:        m.sel = 2'd0;
      7'h37, 7'h17, 7'h6F: m.sel = 2'd1;
      7'h13, 7'h03, 7'h67: m.sel = 2'd2;
      7'h23:               m.sel = 2'd3;
      default: begin
        m.sel = 2'd0;
        m.ill = 1'b1;
      end
    endcase
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Scoreboard: consume compared before accept is recorded in the same cycle.
  always @(negedge clk) begin
    exp_t o;
    exp_t e;
    if (reset === 1'b1 || flush === 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        o = '{opb_sel, opb_imi, opb_ims, opb_pc, rs2_addr, illegal};
        if (sb.size() == 0) begin
          chk("sb_unexpected", 128'(o), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_entry", 128'(o), 128'(e));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1)
        sb.push_back(model(in_inst, in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_inst  = i;
    in_pc    = p;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_outputs", 128'({opb_sel, opb_imi, opb_ims, opb_pc, rs2_addr, illegal}),
        128'(0));
    chk("rst_in_ready_after", 128'(in_ready), 128'(1));
    step();

    // addi x1,x2,-5
    send1(32'hFFB10093, 32'h100);
    @(negedge clk);
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_sel", 128'(opb_sel), 128'(2));
    chk("addi_imi", 128'(opb_imi), 128'(32'hFFFFFFFB));
    chk("addi_ims", 128'(opb_ims), 128'(32'hFFFFFFE1));
    chk("addi_rs2", 128'(rs2_addr), 128'(27));
    chk("addi_pc", 128'(opb_pc), 128'(32'h100));
    chk("addi_ill", 128'(illegal), 128'(0));
    step();

    send1(32'h00512423, 32'h104);
    @(negedge clk);
    chk("sw_sel", 128'(opb_sel), 128'(3));
    chk("sw_ims", 128'(opb_ims), 128'(8));
    chk("sw_rs2", 128'(rs2_addr), 128'(5));
    step();
    send1(32'h002081B3, 32'h108);
    @(negedge clk);
    chk("add_sel", 128'(opb_sel), 128'(0));
    step();
    send1(32'h0000006F, 32'h10C);
    @(negedge clk);
    chk("jal_sel", 128'(opb_sel), 128'(1));
    step();

    // back-pressure: A to main, B to skid, C stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00000013;
    in_pc     = 32'h200;
    step();
    in_inst   = 32'h00000033;
    in_pc     = 32'h204;
    step();
    @(negedge clk);
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_main_a", 128'(opb_pc), 128'(32'h200));
    in_inst   = 32'h00000023;
    in_pc     = 32'h208;
    step();
    step();
    @(negedge clk);
    chk("bp_stalled", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_main_b", 128'(opb_pc), 128'(32'h204));
    chk("bp_in_ready_back", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_main_c", 128'(opb_pc), 128'(32'h208));
    chk("bp_c_valid", 128'(out_valid), 128'(1));
    step();

    // flush with both entries held and a live input
    out_ready = 1'b0;
    send1(32'h00000017, 32'h300);
    send1(32'h00000037, 32'h304);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00000067;
    in_pc    = 32'h308;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("fl_no_ghost", 128'(out_valid), 128'(0));

    send1(32'h0000007F, 32'h400);
    @(negedge clk);
    chk("ill_flag", 128'(illegal), 128'(1));
    chk("ill_sel", 128'(opb_sel), 128'(0));
    step();
    send1(32'h00000003, 32'h404);
    @(negedge clk);
    chk("legal_after_ill", 128'(illegal), 128'(0));
    chk("load_sel", 128'(opb_sel), 128'(2));
    step();

    // reset with two entries held
    out_ready = 1'b0;
    send1(32'hFFB10093, 32'h500);
    send1(32'h00512423, 32'h504);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", 128'(in_ready), 128'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 128'(out_valid), 128'(0));
    chk("rst2_outputs", 128'({opb_sel, opb_imi, opb_ims, opb_pc, rs2_addr, illegal}),
        128'(0));
    chk("rst2_in_ready_after", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    send1(32'h00000063, 32'h600);
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_pc", 128'(opb_pc), 128'(32'h600));
    step();
    step();
    @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
